// File: rtl/jedro_1_lsu_pkg.sv
// Shared types and helpers for the jedro_1 load/store unit.
package jedro_1_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE  = 2'b00,
        LSU_HALF  = 2'b01,
        LSU_WORD  = 2'b10,
        LSU_DWORD = 2'b11
    } lsu_size_e;

    typedef enum logic {
        IDLE,
        READ_WAIT
    } lsu_state_e;

    // Right-aligned byte mask covering one access of the given size.
    function automatic logic [7:0] lsu_byte_mask(input lsu_size_e size);
        logic [7:0] mask;
        unique case (size)
            LSU_BYTE: mask = 8'h01;
            LSU_HALF: mask = 8'h03;
            LSU_WORD: mask = 8'h0F;
            default:  mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/jedro_1_lsu_load_align.sv
// Load data alignment: shifts the addressed bytes down, masks to the access
// size and sign/zero-extends to the full bus width.
module jedro_1_lsu_load_align
    import jedro_1_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         rdata_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset_i,
    input  lsu_size_e                     size_i,
    input  logic                          sign_ext_i,
    output logic [DATA_WIDTH-1:0]         data_o
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [BYTES-1:0]      bm;
    logic                  sign_bit;

    always_comb begin
        shifted   = rdata_i >> {offset_i, 3'b000};
        bm        = BYTES'(lsu_byte_mask(size_i));
        lane_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            lane_mask[i*8 +: 8] = {8{bm[i]}};
        end
        unique case (size_i)
            LSU_BYTE: sign_bit = shifted[7];
            LSU_HALF: sign_bit = shifted[15];
            LSU_WORD: sign_bit = shifted[31];
            default:  sign_bit = shifted[DATA_WIDTH-1];
        endcase
        // Full-width accesses have an all-ones mask, so extension is a no-op.
        data_o = (shifted & lane_mask) | ((sign_ext_i && sign_bit) ? ~lane_mask : '0);
    end

endmodule

// File: rtl/jedro_1_lsu_gen.sv
// jedro_1 load/store unit for a one-cycle-latency byte-write RAM.
// Define JEDRO_1_LSU_ALIGN_CHECK_EN to fault misaligned accesses instead of aligning them down.
module jedro_1_lsu_gen
    import jedro_1_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      is_write_i,
    input  logic [1:0]                size_i,
    input  logic                      sign_ext_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [4:0]                rd_addr_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [4:0]                rd_addr_o,
    output logic                      rdata_valid_o,
    output logic                      access_err_o,
    output logic [ADDR_WIDTH-1:0]     err_addr_o,
    output logic                      mem_en_o,
    output logic [DATA_WIDTH/8-1:0]   mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);

    lsu_state_e            state_q, state_d;
    lsu_size_e             size;
    logic [OFFW-1:0]       off_raw, off_low, off;
    logic [BYTES-1:0]      mask;
    logic [DATA_WIDTH-1:0] wdata_rep, load_data;
    logic                  oversize, fault, accept, go, load_go;

    logic [OFFW-1:0]       off_q;
    lsu_size_e             size_q;
    logic                  sext_q;
    logic [4:0]            tag_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [4:0]            rd_q;
    logic                  valid_q, err_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    always_comb begin
        size     = lsu_size_e'(size_i);
        off_raw  = addr_i[OFFW-1:0];
        off_low  = OFFW'((4'd1 << size_i) - 4'd1);
        oversize = (size == LSU_DWORD) && (DATA_WIDTH == 32);
`ifdef JEDRO_1_LSU_ALIGN_CHECK_EN
        fault    = oversize || (|(off_raw & off_low));
        off      = off_raw;
`else
        fault    = oversize;
        off      = off_raw & ~off_low;
`endif
        accept   = req_valid_i && (state_q == IDLE);
        go       = accept && !fault;
        load_go  = go && !is_write_i;
        mask     = BYTES'(lsu_byte_mask(size));

        unique case (size)
            LSU_BYTE: wdata_rep = {BYTES{wdata_i[7:0]}};
            LSU_HALF: wdata_rep = {(BYTES/2){wdata_i[15:0]}};
            LSU_WORD: wdata_rep = {(BYTES/4){wdata_i[31:0]}};
            default:  wdata_rep = wdata_i;
        endcase

        req_ready_o = (state_q == IDLE);
        mem_en_o    = go;
        mem_we_o    = (go && is_write_i) ? (mask << off) : '0;
        mem_addr_o  = go ? (addr_i >> OFFW) : '0;
        mem_wdata_o = (go && is_write_i) ? wdata_rep : '0;

        state_d = state_q;
        unique case (state_q)
            IDLE:      if (load_go) state_d = READ_WAIT;
            READ_WAIT: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    jedro_1_lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata_i    (mem_rdata_i),
        .offset_i   (off_q),
        .size_i     (size_q),
        .sign_ext_i (sext_q),
        .data_o     (load_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            off_q      <= '0;
            size_q     <= LSU_BYTE;
            sext_q     <= 1'b0;
            tag_q      <= '0;
            rdata_q    <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == READ_WAIT);
            err_q   <= accept && fault;
            if (accept && fault) err_addr_q <= addr_i;
            if (load_go) begin
                off_q  <= off;
                size_q <= size;
                sext_q <= sign_ext_i;
                tag_q  <= rd_addr_i;
            end
            if (state_q == READ_WAIT) begin
                rdata_q <= load_data;
                rd_q    <= tag_q;
            end
        end
    end

    assign rdata_o       = rdata_q;
    assign rd_addr_o     = rd_q;
    assign rdata_valid_o = valid_q;
    assign access_err_o  = err_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_jedro_1_lsu_gen.sv
// Directed bench for jedro_1_lsu_gen: 32-bit and 64-bit instances, each with a RAM model.
module tb_jedro_1_lsu_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // 32-bit instance
    logic        a_valid, a_wr, a_sx, a_ready, a_rvalid, a_err, a_en;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata, a_erraddr, a_maddr, a_mwdata, a_mrdata;
    logic [4:0]  a_tag, a_rd;
    logic [3:0]  a_we;
    logic [31:0] ram_a [16];

    // 64-bit instance
    logic        b_valid, b_wr, b_sx, b_ready, b_rvalid, b_err, b_en;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_erraddr, b_maddr;
    logic [63:0] b_wdata, b_rdata, b_mwdata, b_mrdata;
    logic [4:0]  b_tag, b_rd;
    logic [7:0]  b_we;
    logic [63:0] ram_b [16];

    jedro_1_lsu_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(a_valid), .req_ready_o(a_ready),
        .is_write_i(a_wr), .size_i(a_size), .sign_ext_i(a_sx), .addr_i(a_addr),
        .wdata_i(a_wdata), .rd_addr_i(a_tag), .rdata_o(a_rdata), .rd_addr_o(a_rd),
        .rdata_valid_o(a_rvalid), .access_err_o(a_err), .err_addr_o(a_erraddr),
        .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata),
        .mem_rdata_i(a_mrdata)
    );

    jedro_1_lsu_gen #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .is_write_i(b_wr), .size_i(b_size), .sign_ext_i(b_sx), .addr_i(b_addr),
        .wdata_i(b_wdata), .rd_addr_i(b_tag), .rdata_o(b_rdata), .rd_addr_o(b_rd),
        .rdata_valid_o(b_rvalid), .access_err_o(b_err), .err_addr_o(b_erraddr),
        .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata),
        .mem_rdata_i(b_mrdata)
    );

    always @(posedge clk) begin
        if (a_en) begin
            for (int i = 0; i < 4; i++)
                if (a_we[i]) ram_a[a_maddr[3:0]][i*8 +: 8] <= a_mwdata[i*8 +: 8];
            a_mrdata <= ram_a[a_maddr[3:0]];
        end
        if (b_en) begin
            for (int j = 0; j < 8; j++)
                if (b_we[j]) ram_b[b_maddr[3:0]][j*8 +: 8] <= b_mwdata[j*8 +: 8];
            b_mrdata <= ram_b[b_maddr[3:0]];
        end
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the 32-bit instance: every load result pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && a_rvalid === 1'b1) begin
            chk("err_valid_excl", a_err, 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", a_rvalid, 0);
            end else begin
                e = sb_q.pop_front();
                chk("load_data", a_rdata, e.data);
                chk("load_tag", a_rd, e.tag);
            end
        end
    end

    task automatic a_drive(input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] tg);
        a_valid = 1'b1; a_wr = wr; a_size = sz; a_sx = sx; a_addr = ad; a_wdata = wd; a_tag = tg;
    endtask

    task automatic a_idle();
        a_valid = 1'b0; a_wr = 1'b0; a_size = 2'b00; a_sx = 1'b0;
        a_addr = '0; a_wdata = '0; a_tag = '0;
    endtask

    task automatic b_idle();
        b_valid = 1'b0; b_wr = 1'b0; b_size = 2'b00; b_sx = 1'b0;
        b_addr = '0; b_wdata = '0; b_tag = '0;
    endtask

    task automatic a_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                           input logic [3:0] ewe, input logic [31:0] emaddr,
                           input logic [31:0] ewdata);
        a_drive(1'b1, sz, 1'b0, ad, wd, 5'd0);
        #1;
        chk("st_en", a_en, 1);
        chk("st_we", a_we, ewe);
        chk("st_maddr", a_maddr, emaddr);
        chk("st_wdata", a_mwdata, ewdata);
        @(posedge clk); #1;
    endtask

    task automatic a_load(input logic [1:0] sz, input logic sx, input logic [31:0] ad,
                          input logic [4:0] tg, input logic [31:0] ed,
                          input logic [31:0] emaddr);
        exp_t e;
        int n;
        a_drive(1'b0, sz, sx, ad, 32'h0, tg);
        e.tag = tg; e.data = ed;
        sb_q.push_back(e);
        #1;
        chk("ld_en", a_en, 1);
        chk("ld_we", a_we, 0);
        chk("ld_maddr", a_maddr, emaddr);
        @(posedge clk); #1;
        a_idle();
        @(negedge clk); #1;
        chk("ld_wait_ready", a_ready, 0);
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ld_latency", n, 1);
    endtask

    task automatic b_load(input logic [1:0] sz, input logic sx, input logic [31:0] ad,
                          input logic [4:0] tg, input logic [63:0] ed);
        b_valid = 1'b1; b_wr = 1'b0; b_size = sz; b_sx = sx; b_addr = ad; b_tag = tg;
        #1;
        chk("b_ld_en", b_en, 1);
        @(posedge clk); #1;
        b_idle();
        @(negedge clk); #1;
        chk("b_wait_valid", b_rvalid, 0);
        chk("b_wait_ready", b_ready, 0);
        @(negedge clk); #1;
        chk("b_valid", b_rvalid, 1);
        chk("b_data", b_rdata, ed);
        chk("b_tag", b_rd, tg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        a_idle();
        b_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", a_rdata, 0);
        chk("rst_rd", a_rd, 0);
        chk("rst_valid", a_rvalid, 0);
        chk("rst_err", a_err, 0);
        chk("rst_erraddr", a_erraddr, 0);
        chk("rst_en", a_en, 0);
        chk("rst_we", a_we, 0);
        chk("rst_maddr", a_maddr, 0);
        chk("rst_mwdata", a_mwdata, 0);
        chk("rst_ready", a_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        // Back-to-back byte stores, then byte loads of both.
        a_store(2'b00, 32'h0, 32'h0000_00FF, 4'b0001, 32'h0, 32'hFFFF_FFFF);
        a_store(2'b00, 32'h4, 32'h0000_00FF, 4'b0001, 32'h1, 32'hFFFF_FFFF);
        a_idle();
        a_load(2'b00, 1'b0, 32'h0, 5'd3, 32'h0000_00FF, 32'h0);
        a_load(2'b00, 1'b0, 32'h4, 5'd4, 32'h0000_00FF, 32'h1);

        // Sign/zero extension from each lane.
        a_store(2'b10, 32'h0, 32'h80FF_7F01, 4'b1111, 32'h0, 32'h80FF_7F01);
        a_idle();
        a_load(2'b00, 1'b1, 32'h1, 5'd5, 32'h0000_007F, 32'h0);
        a_load(2'b00, 1'b1, 32'h2, 5'd6, 32'hFFFF_FFFF, 32'h0);
        a_load(2'b00, 1'b1, 32'h3, 5'd7, 32'hFFFF_FF80, 32'h0);
        a_load(2'b01, 1'b0, 32'h2, 5'd8, 32'h0000_80FF, 32'h0);

        a_store(2'b01, 32'h6, 32'h0000_ABCD, 4'b1100, 32'h1, 32'hABCD_ABCD);
        a_idle();
        chk("rdata_hold", a_rdata, 32'h0000_80FF);
        chk("rd_hold", a_rd, 5'd8);

        // Misaligned word load.
`ifdef JEDRO_1_LSU_ALIGN_CHECK_EN
        a_drive(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 5'd9);
        #1;
        chk("misal_en", a_en, 0);
        chk("misal_we", a_we, 0);
        @(posedge clk); #1;
        a_idle();
        @(negedge clk); #1;
        chk("misal_err", a_err, 1);
        chk("misal_erraddr", a_erraddr, 32'h2);
        chk("misal_ready", a_ready, 1);
        @(posedge clk); #1;
        chk("misal_err_pulse", a_err, 0);
`else
        a_load(2'b10, 1'b0, 32'h2, 5'd9, 32'h80FF_7F01, 32'h0);
        chk("misal_no_err", a_err, 0);
`endif

        // Doubleword on a 32-bit bus always faults.
        a_drive(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 5'd10);
        #1;
        chk("ovs_en", a_en, 0);
        @(posedge clk); #1;
        a_idle();
        @(negedge clk); #1;
        chk("ovs_err", a_err, 1);
        chk("ovs_erraddr", a_erraddr, 32'h10);
        chk("ovs_valid", a_rvalid, 0);
        @(posedge clk); #1;
        chk("ovs_err_pulse", a_err, 0);

        // Reset in the middle of a load: no result may appear afterwards.
        a_drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd11);
        @(posedge clk); #1;
        a_idle();
        @(negedge clk);
        chk("mid_ready", a_ready, 0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_rst_rdata", a_rdata, 0);
        chk("mid_rst_rd", a_rd, 0);
        chk("mid_rst_valid", a_rvalid, 0);
        chk("mid_rst_erraddr", a_erraddr, 0);
        chk("mid_rst_ready", a_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        a_store(2'b00, 32'h8, 32'h0000_005A, 4'b0001, 32'h2, 32'h5A5A_5A5A);
        a_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_valid", a_rvalid, 0);

        // 64-bit instance: doubleword store and loads of various sizes.
        b_valid = 1'b1; b_wr = 1'b1; b_size = 2'b11; b_addr = 32'h8;
        b_wdata = 64'h1122_3344_5566_7788;
        #1;
        chk("sd_en", b_en, 1);
        chk("sd_we", b_we, 8'hFF);
        chk("sd_maddr", b_maddr, 32'h1);
        chk("sd_wdata", b_mwdata, 64'h1122_3344_5566_7788);
        @(posedge clk); #1;
        b_idle();
        b_load(2'b11, 1'b0, 32'h8,  5'd7,  64'h1122_3344_5566_7788);
        b_load(2'b10, 1'b1, 32'hC,  5'd12, 64'h0000_0000_1122_3344);
        b_load(2'b00, 1'b1, 32'h8,  5'd13, 64'hFFFF_FFFF_FFFF_FF88);
        b_load(2'b01, 1'b0, 32'hE,  5'd14, 64'h0000_0000_0000_1122);
        chk("b_no_err", b_err, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jedro_1_lsu_gen.md
# jedro_1_lsu_gen

Parametrised load/store unit between the jedro_1 execute stage and a synchronous byte-write data RAM with one-cycle read latency. Generalises store-byte handling to all RISC-V access sizes (byte, half, word, and doubleword when DATA_WIDTH=64). It generates byte enables and lane-replicated write data, extracts and sign/zero-extends load data, and reports faulting accesses. The unit keeps at most one load outstanding.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; legal values 32 or 64. BYTES = DATA_WIDTH/8, OFFW = log2(BYTES).
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rstn_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  access request
- req_ready_o  out  1  unit can accept a request this cycle
- is_write_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 doubleword
- sign_ext_i  in  1  loads only; 1 = sign-extend, 0 = zero-extend
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  store data, right-aligned
- rd_addr_i  in  5  destination register tag for loads
- rdata_o  out  DATA_WIDTH  extended load result
- rd_addr_o  out  5  tag returned with rdata_o
- rdata_valid_o  out  1  one-cycle pulse marking a valid load result
- access_err_o  out  1  one-cycle fault pulse
- err_addr_o  out  ADDR_WIDTH  address of the last faulting request
- mem_en_o  out  1  RAM enable
- mem_we_o  out  BYTES  per-byte write enables
- mem_addr_o  out  ADDR_WIDTH  word index, equal to addr_i >> OFFW
- mem_wdata_o  out  DATA_WIDTH  lane-replicated store data
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after the read enable

## Operation
- FSM states: IDLE and READ_WAIT.
- req_ready_o = (state == IDLE).
- A request is accepted on a rising edge where req_valid_i && req_ready_o.
- Memory-side outputs are combinational from the request while in IDLE with req_valid_i high, so the RAM samples them on the accept edge. They are 0 whenever no request is accepted.
- Byte-enable mask by size:
  - byte: 1
  - half: 2'b11
  - word: 4'hF
  - dword: 8'hFF
- mem_we_o = mask << addr_i[OFFW-1:0] for stores, and 0 for loads.
- mem_wdata_o replicates the low byte, half or word of wdata_i across all lanes.
- Store path: completes on the accept edge; the FSM stays in IDLE.
- Load path: on accept, the unit latches offset, size, sign_ext and the tag, then moves to READ_WAIT. In READ_WAIT it:
  - shifts mem_rdata_i right by offset*8,
  - masks to the access size and extends,
  - registers rdata_o and rd_addr_o,
  - pulses rdata_valid_o,
  - returns to IDLE.
- Fault conditions:
  - size_i = 11 with DATA_WIDTH = 32 always faults.
  - Misalignment faults only when the checking feature is enabled (see Configuration).
- On a fault the unit:
  - does not drive mem_en_o or mem_we_o,
  - pulses access_err_o on the next cycle,
  - latches err_addr_o,
  - stays in IDLE.
- rdata_o and rd_addr_o hold their value until the next load completes.

## Timing
- Reset: state IDLE. rdata_o, rd_addr_o, rdata_valid_o, access_err_o, err_addr_o are all 0, and memory outputs are 0.
- Store latency: 0 cycles. Back-to-back stores run at one per cycle.
- Load latency: accept at edge N; rdata_valid_o is high during the cycle following edge N+1. req_ready_o is low during that READ_WAIT cycle.
- In the cycle rdata_valid_o is high the FSM is already in IDLE, so a new request may be accepted. Sustained load throughput is therefore one per 2 cycles.
- Reset asserted mid-load: the pending load is discarded and no rdata_valid_o is produced after reset release.
- access_err_o and rdata_valid_o are never high in the same cycle.

## Configuration
- JEDRO_1_LSU_ALIGN_CHECK_EN defined: a half, word or dword access whose addr_i is not size-aligned faults as described above.
- Macro undefined:
  - Offset bits below the access size are cleared, so the access is forced down to the aligned address.
  - Misalignment never raises access_err_o.
  - The oversize fault remains.

## Structure
- jedro_1_lsu_pkg holds:
  - the lsu_size_e enum (LSU_BYTE, LSU_HALF, LSU_WORD, LSU_DWORD),
  - the lsu_state_e enum (IDLE, READ_WAIT),
  - a function that returns the byte mask for a given size.
- One combinational sub-module, jedro_1_lsu_load_align, performs the shift, mask and extend from (rdata, offset, size, sign_ext). It is reused by the core's future cache refill path.

## Test plan
- sb 0xFF to addresses 0 and 4, then lbu from both -> mem_we_o = 4'b0001 on both stores; rdata_o = 0x000000FF twice, rd_addr_o matches each request's tag.
- Word 0x80FF7F01 stored at 0, then lb at 1, 2, 3 with sign_ext = 1 -> 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; lhu at 2 -> 0x000080FF.
- sh 0xABCD at address 6 -> mem_addr_o = 1, mem_we_o = 4'b1100, mem_wdata_o = 0xABCDABCD.
- With JEDRO_1_LSU_ALIGN_CHECK_EN, lw at 0x2 -> no mem_en_o, access_err_o pulse, err_addr_o = 0x2. Without the macro -> a word read from word index 0.
- DATA_WIDTH = 64: sd 0x1122334455667788 at 8, then ld with sign_ext = 0 -> identical value returned after 2 cycles; size 11 with DATA_WIDTH = 32 -> access_err_o.
- rstn_i low during READ_WAIT -> no rdata_valid_o after release, all outputs 0, next request accepted in the first cycle after release.
